// File: rtl/jk_bank_counter.sv
// WIDTH-bit bank of JK-style storage elements with per-bit JK/T/D/SR modes,
// whole-bank up/down counting built as a synchronous JK chain, and a serial shift.
module jk_bank_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qnot,
  output logic             tc,
  output logic             sr_err
);

  localparam logic [2:0] ModeHold  = 3'd0;
  localparam logic [2:0] ModeJk    = 3'd1;
  localparam logic [2:0] ModeT     = 3'd2;
  localparam logic [2:0] ModeD     = 3'd3;
  localparam logic [2:0] ModeSr    = 3'd4;
  localparam logic [2:0] ModeCount = 3'd5;
  localparam logic [2:0] ModeShift = 3'd6;
  localparam logic [2:0] ModeClear = 3'd7;

  localparam logic [WIDTH-1:0] RstVal = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_sr_err;
  logic [WIDTH-1:0] w_q_d;
  logic             w_sr_err_d;
  logic [WIDTH-1:0] w_cnt_toggle;
  logic             w_carry;

  // Ripple-free toggle enables: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    w_cnt_toggle = '0;
    w_carry      = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_toggle[i] = w_carry;
      w_carry         = w_carry & (up ? r_q[i] : ~r_q[i]);
    end
  end

  always_comb begin
    w_q_d      = r_q;
    w_sr_err_d = 1'b0;
    if (en) begin
      unique case (mode)
        ModeHold: w_q_d = r_q;
        ModeJk: begin
          for (int i = 0; i < WIDTH; i++) begin
            unique case ({j[i], k[i]})
              2'b00:   w_q_d[i] = r_q[i];
              2'b01:   w_q_d[i] = 1'b0;
              2'b10:   w_q_d[i] = 1'b1;
              default: w_q_d[i] = ~r_q[i];
            endcase
          end
        end
        ModeT: w_q_d = r_q ^ j;
        ModeD: w_q_d = j;
        ModeSr: begin
          // S=R=1 leaves the bit alone but is flagged as a usage error.
          w_q_d      = (r_q | (j & ~k)) & ~(k & ~j);
          w_sr_err_d = |(j & k);
        end
        ModeCount: w_q_d = r_q ^ w_cnt_toggle;
        ModeShift: w_q_d = {r_q[WIDTH-2:0], j[0]};
        ModeClear: w_q_d = RstVal;
        default:   w_q_d = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= RstVal;
      r_sr_err <= 1'b0;
    end else begin
      r_q      <= w_q_d;
      r_sr_err <= w_sr_err_d;
    end
  end

  assign q      = r_q;
  assign qnot   = ~r_q;
  assign sr_err = r_sr_err;
  assign tc     = en & (mode == ModeCount) & (up ? (&r_q) : ~(|r_q));

endmodule

// File: tb/tb_jk_bank_counter.sv
// Directed-vector bench for jk_bank_counter (WIDTH=4, RESET_VAL=5) with a queue
// scoreboard: the driver pushes expected post-edge state, a monitor pops and compares.
module tb_jk_bank_counter;

  localparam int unsigned W = 4;

  localparam logic [2:0] MHold  = 3'd0;
  localparam logic [2:0] MJk    = 3'd1;
  localparam logic [2:0] MT     = 3'd2;
  localparam logic [2:0] MD     = 3'd3;
  localparam logic [2:0] MSr    = 3'd4;
  localparam logic [2:0] MCount = 3'd5;
  localparam logic [2:0] MShift = 3'd6;
  localparam logic [2:0] MClear = 3'd7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b1;
  logic [2:0]   mode = MCount;
  logic [W-1:0] j = '0;
  logic [W-1:0] k = '0;
  logic         up = 1'b1;
  logic [W-1:0] q;
  logic [W-1:0] qnot;
  logic         tc;
  logic         sr_err;

  always #5 clk = ~clk;

  jk_bank_counter #(
    .WIDTH    (W),
    .RESET_VAL(32'h5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .j     (j),
    .k     (k),
    .up    (up),
    .q     (q),
    .qnot  (qnot),
    .tc    (tc),
    .sr_err(sr_err)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         sr;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  logic [W-1:0] exp_qn;
  int           n_vec = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        cur    = sb.pop_front();
        exp_qn = ~cur.q;
        chk("q", {28'd0, q}, {28'd0, cur.q});
        chk("qnot", {28'd0, qnot}, {28'd0, exp_qn});
        chk("tc", {31'd0, tc}, {31'd0, cur.tc});
        chk("sr_err", {31'd0, sr_err}, {31'd0, cur.sr});
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] jj,
                       input logic [W-1:0] kk, input logic u, input logic [W-1:0] eq,
                       input logic etc, input logic esr);
    @(negedge clk);
    reset = r;
    en    = e;
    mode  = m;
    j     = jj;
    k     = kk;
    up    = u;
    sb.push_back(exp_t'{q: eq, tc: etc, sr: esr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //     rst  en   mode    j        k        up   q        tc   sr
    // Reset with COUNT active, then count up from RESET_VAL.
    drive(1, 1, MCount, 4'h0, 4'h0, 1, 4'h5, 0, 0);
    drive(1, 1, MCount, 4'h0, 4'h0, 1, 4'h5, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'h6, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'h7, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'h8, 0, 0);
    // JK: bit3 set, bit2 reset, bit1 toggle, bit0 hold; then toggle all; then hold.
    drive(0, 1, MD,     4'h0, 4'h0, 1, 4'h0, 0, 0);
    drive(0, 1, MJk,    4'hA, 4'h6, 1, 4'hA, 0, 0);
    drive(0, 1, MJk,    4'hF, 4'hF, 1, 4'h5, 0, 0);
    drive(0, 1, MJk,    4'h0, 4'h0, 1, 4'h5, 0, 0);
    // COUNT up wrap at all-ones, down wrap at zero, multi-bit carry.
    drive(0, 1, MD,     4'hE, 4'h0, 1, 4'hE, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'hF, 1, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'h0, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 0, 4'hF, 0, 0);
    drive(0, 1, MD,     4'h1, 4'h0, 0, 4'h1, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 0, 4'h0, 1, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 0, 4'hF, 0, 0);
    drive(0, 1, MD,     4'h3, 4'h0, 1, 4'h3, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'h4, 0, 0);
    // SR with one S=R=1 bit, then clean SR.
    drive(0, 1, MD,     4'h8, 4'h0, 1, 4'h8, 0, 0);
    drive(0, 1, MSr,    4'h3, 4'h5, 1, 4'hA, 0, 1);
    drive(0, 1, MHold,  4'h0, 4'h0, 1, 4'hA, 0, 0);
    drive(0, 1, MSr,    4'h4, 4'h8, 1, 4'h6, 0, 0);
    // T mode.
    drive(0, 1, MT,     4'h3, 4'hF, 1, 4'h5, 0, 0);
    // SHIFT in 1,0,1 then CLEAR.
    drive(0, 1, MD,     4'h9, 4'h0, 1, 4'h9, 0, 0);
    drive(0, 1, MShift, 4'h1, 4'h0, 1, 4'h3, 0, 0);
    drive(0, 1, MShift, 4'h0, 4'h0, 1, 4'h6, 0, 0);
    drive(0, 1, MShift, 4'h1, 4'h0, 1, 4'hD, 0, 0);
    drive(0, 1, MClear, 4'h0, 4'h0, 1, 4'h5, 0, 0);
    // en=0 holds and masks tc; reset mid-count discards the count.
    drive(0, 1, MD,     4'h7, 4'h0, 1, 4'h7, 0, 0);
    drive(0, 0, MCount, 4'h0, 4'h0, 1, 4'h7, 0, 0);
    drive(0, 0, MCount, 4'h0, 4'h0, 1, 4'h7, 0, 0);
    drive(0, 0, MCount, 4'h0, 4'h0, 1, 4'h7, 0, 0);
    drive(1, 1, MCount, 4'h0, 4'h0, 1, 4'h5, 0, 0);
    drive(0, 1, MCount, 4'h0, 4'h0, 1, 4'h6, 0, 0);
    // sr_err cleared by en=0 and by reset.
    drive(0, 1, MSr,    4'hF, 4'hF, 1, 4'h6, 0, 1);
    drive(0, 0, MSr,    4'hF, 4'hF, 1, 4'h6, 0, 0);
    drive(0, 1, MSr,    4'hF, 4'hF, 1, 4'h6, 0, 1);
    drive(1, 1, MSr,    4'hF, 4'hF, 1, 4'h5, 0, 0);
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, 0 required", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
